// File: rtl/alpha_feed_sequencer_pkg.sv
// Shared constants for the alpha feed sequencer: default sizing, FSM state
// encodings and the floating-point zero used for padded operands.
package alpha_feed_sequencer_pkg;

   localparam int ORDER   = 12;   // maximum LPC order
   localparam int DATA_W  = 32;   // IEEE-754 single word
   localparam int ADDR_W  = 4;    // coefficient RAM address width
   localparam int TIMEOUT = 64;   // cycles allowed in WAIT
   localparam int M_W     = 4;    // width of order m and pair index k

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   // Sequencer states (plain constants so legacy code can share them)
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;

   // Index of the final pair for order m: P-1 = ((m+2)>>1)-1 = m>>1
   function automatic logic [M_W-1:0] last_pair_index(input logic [M_W-1:0] m);
      return m >> 1;
   endfunction

endpackage

// File: rtl/alpha_pair_addr_gen.sv
// Maps (order m, pair index k) to the four coefficient RAM addresses used by
// one beat of the alpha dot product, plus the pad flag marking a beat whose
// second product (model[2k+1] * acf[m-2k]) lies beyond the order.
// Purely combinational; the sequencer registers the results.
module alpha_pair_addr_gen
   import alpha_feed_sequencer_pkg::*;
#(
   parameter int ADDR_W = alpha_feed_sequencer_pkg::ADDR_W
) (
   input  logic [M_W-1:0]    m,
   input  logic [M_W-1:0]    k,
   output logic [ADDR_W-1:0] acf1_addr,
   output logic [ADDR_W-1:0] acf2_addr,
   output logic [ADDR_W-1:0] model1_addr,
   output logic [ADDR_W-1:0] model2_addr,
   output logic              pad
);

   // Wide enough that m+1 and 2k+1 never wrap before truncation
   localparam int CW = ((ADDR_W > M_W) ? ADDR_W : M_W) + 2;

   logic [CW-1:0] m_ext;
   logic [CW-1:0] two_k;

   // Address arithmetic for pair k; m-2k never goes negative for k <= m>>1
   always_comb begin
      m_ext       = CW'(m);
      two_k       = CW'(k) << 1;
      model1_addr = ADDR_W'(two_k);
      model2_addr = ADDR_W'(two_k | CW'(1));
      acf1_addr   = ADDR_W'(m_ext - two_k);
      acf2_addr   = ADDR_W'(m_ext + CW'(1) - two_k);
      pad         = ((two_k | CW'(1)) > m_ext);
   end

endmodule

// File: rtl/alpha_feed_sequencer.sv
// Sequences the pipelined alpha dot-product unit for one Levinson-Durbin
// order: clears the unit, walks the ACF / model RAMs pair by pair, feeds
// the operand pairs with a valid strobe and returns the unit's alpha.
// RAM reads have one cycle of latency, so each beat's operands appear the
// cycle after its addresses, directly from the RAM read registers.
module alpha_feed_sequencer #(
   parameter int ORDER   = alpha_feed_sequencer_pkg::ORDER,
   parameter int DATA_W  = alpha_feed_sequencer_pkg::DATA_W,
   parameter int ADDR_W  = alpha_feed_sequencer_pkg::ADDR_W,
   parameter int TIMEOUT = alpha_feed_sequencer_pkg::TIMEOUT
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iEnable,
   input  logic              iStart,
   input  logic [3:0]        iM,
   output logic [ADDR_W-1:0] oACFAddr1,
   output logic [ADDR_W-1:0] oACFAddr2,
   input  logic [DATA_W-1:0] iACFData1,
   input  logic [DATA_W-1:0] iACFData2,
   output logic [ADDR_W-1:0] oModelAddr1,
   output logic [ADDR_W-1:0] oModelAddr2,
   input  logic [DATA_W-1:0] iModelData1,
   input  logic [DATA_W-1:0] iModelData2,
   output logic              oCalcReset,
   output logic              oCalcValid,
   output logic [DATA_W-1:0] oCalcACF1,
   output logic [DATA_W-1:0] oCalcACF2,
   output logic [DATA_W-1:0] oCalcModel1,
   output logic [DATA_W-1:0] oCalcModel2,
   output logic [3:0]        oCalcM,
   input  logic [DATA_W-1:0] iCalcAlpha,
   input  logic              iCalcDone,
   output logic [DATA_W-1:0] oAlpha,
   output logic              oDone,
   output logic              oBusy,
   output logic              oError
);
   import alpha_feed_sequencer_pkg::*;

   localparam int              CNT_W        = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [M_W-1:0]   ORDER_MAX    = M_W'(ORDER);
   // Lanes: 0 = ACF1, 1 = ACF2, 2 = Model1, 3 = Model2; ACF1/Model2 pad
   localparam logic [3:0]       LANE_PADDED  = 4'b1001;

   logic [2:0]        state_reg;
   logic [M_W-1:0]    m_reg;
   logic [M_W-1:0]    k_reg;
   logic [CNT_W-1:0]  wait_cnt_reg;
   logic [ADDR_W-1:0] acf1_addr_reg;
   logic [ADDR_W-1:0] acf2_addr_reg;
   logic [ADDR_W-1:0] model1_addr_reg;
   logic [ADDR_W-1:0] model2_addr_reg;
   logic              addr_pad_reg;
   logic              beat_pad_reg;
   logic              valid_reg;
   logic              calc_reset_reg;
   logic              done_reg;
   logic              error_reg;
   logic [DATA_W-1:0] alpha_reg;

   logic [M_W-1:0]    k_next;
   logic [ADDR_W-1:0] gen_acf1;
   logic [ADDR_W-1:0] gen_acf2;
   logic [ADDR_W-1:0] gen_model1;
   logic [ADDR_W-1:0] gen_model2;
   logic              gen_pad;
   logic              m_legal;
   logic              last_pair;

   // Pair to address next: pair 0 when leaving CLEAR, otherwise k+1
   always_comb begin
      k_next    = (state_reg == ST_CLEAR) ? '0 : (k_reg + M_W'(1));
      m_legal   = (iM != '0) && (iM <= ORDER_MAX);
      last_pair = (k_reg == last_pair_index(m_reg));
   end

   alpha_pair_addr_gen #(
      .ADDR_W      (ADDR_W)
   ) u_addr_gen (
      .m           (m_reg),
      .k           (k_next),
      .acf1_addr   (gen_acf1),
      .acf2_addr   (gen_acf2),
      .model1_addr (gen_model1),
      .model2_addr (gen_model2),
      .pad         (gen_pad)
   );

   // Main FSM plus all registered outputs; nothing moves while iEnable is low
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_reg       <= ST_IDLE;
         m_reg           <= '0;
         k_reg           <= '0;
         wait_cnt_reg    <= '0;
         acf1_addr_reg   <= '0;
         acf2_addr_reg   <= '0;
         model1_addr_reg <= '0;
         model2_addr_reg <= '0;
         addr_pad_reg    <= 1'b0;
         beat_pad_reg    <= 1'b0;
         valid_reg       <= 1'b0;
         calc_reset_reg  <= 1'b0;
         done_reg        <= 1'b0;
         error_reg       <= 1'b0;
         alpha_reg       <= '0;
      end else if (iEnable) begin
         calc_reset_reg <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         // A beat is valid the cycle after its addresses were on the bus
         valid_reg      <= (state_reg == ST_ISSUE);
         if (state_reg == ST_ISSUE) begin
            beat_pad_reg <= addr_pad_reg;
         end

         case (state_reg)
            ST_IDLE: begin
               if (iStart) begin
                  if (m_legal) begin
                     m_reg          <= iM;
                     calc_reset_reg <= 1'b1;
                     state_reg      <= ST_CLEAR;
                  end else begin
                     error_reg <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               k_reg           <= k_next;
               acf1_addr_reg   <= gen_acf1;
               acf2_addr_reg   <= gen_acf2;
               model1_addr_reg <= gen_model1;
               model2_addr_reg <= gen_model2;
               addr_pad_reg    <= gen_pad;
               state_reg       <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (last_pair) begin
                  state_reg <= ST_DRAIN;
               end else begin
                  k_reg           <= k_next;
                  acf1_addr_reg   <= gen_acf1;
                  acf2_addr_reg   <= gen_acf2;
                  model1_addr_reg <= gen_model1;
                  model2_addr_reg <= gen_model2;
                  addr_pad_reg    <= gen_pad;
               end
            end
            ST_DRAIN: begin
               wait_cnt_reg <= '0;
               state_reg    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (iCalcDone) begin
                  alpha_reg <= iCalcAlpha;
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
               end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                  error_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Operand lanes: RAM read data, zeroed outside valid beats and on pad lanes
   logic [DATA_W-1:0] lane_data [4];
   logic [DATA_W-1:0] lane_oper [4];

   assign lane_data[0] = iACFData1;
   assign lane_data[1] = iACFData2;
   assign lane_data[2] = iModelData1;
   assign lane_data[3] = iModelData2;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_oper[gi] = (valid_reg && !(LANE_PADDED[gi] && beat_pad_reg))
                                ? lane_data[gi] : DATA_W'(FP_ZERO);
      end
   endgenerate

   assign oCalcACF1   = lane_oper[0];
   assign oCalcACF2   = lane_oper[1];
   assign oCalcModel1 = lane_oper[2];
   assign oCalcModel2 = lane_oper[3];

   assign oACFAddr1   = acf1_addr_reg;
   assign oACFAddr2   = acf2_addr_reg;
   assign oModelAddr1 = model1_addr_reg;
   assign oModelAddr2 = model2_addr_reg;
   assign oCalcReset  = calc_reset_reg;
   assign oCalcValid  = valid_reg;
   assign oCalcM      = m_reg;
   assign oAlpha      = alpha_reg;
   assign oDone       = done_reg;
   assign oBusy       = (state_reg != ST_IDLE);
   assign oError      = error_reg;

endmodule

// File: tb/tb_alpha_feed_sequencer.sv
// Directed bench for alpha_feed_sequencer: drives orders 1, 2 and 12,
// illegal orders, a WAIT timeout, and an enable-freeze / busy-start /
// mid-WAIT reset sequence, checking against hand-computed values.
module tb_alpha_feed_sequencer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              start;
   logic [3:0]        m_in;
   logic [ADDR_W-1:0] acf_addr1, acf_addr2, model_addr1, model_addr2;
   logic [DATA_W-1:0] acf_q1, acf_q2, model_q1, model_q2;
   logic              calc_reset, calc_valid, calc_done;
   logic [DATA_W-1:0] calc_acf1, calc_acf2, calc_model1, calc_model2;
   logic [3:0]        calc_m;
   logic [DATA_W-1:0] calc_alpha, alpha;
   logic              done, busy, err;

   logic [DATA_W-1:0] acf_mem   [16];
   logic [DATA_W-1:0] model_mem [16];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Synchronous dual-read RAMs sharing the global clock enable
   always @(posedge clk) begin
      if (en) begin
         acf_q1   <= acf_mem[acf_addr1];
         acf_q2   <= acf_mem[acf_addr2];
         model_q1 <= model_mem[model_addr1];
         model_q2 <= model_mem[model_addr2];
      end
   end

   alpha_feed_sequencer dut (
      .iClock      (clk),
      .iReset      (rst),
      .iEnable     (en),
      .iStart      (start),
      .iM          (m_in),
      .oACFAddr1   (acf_addr1),
      .oACFAddr2   (acf_addr2),
      .iACFData1   (acf_q1),
      .iACFData2   (acf_q2),
      .oModelAddr1 (model_addr1),
      .oModelAddr2 (model_addr2),
      .iModelData1 (model_q1),
      .iModelData2 (model_q2),
      .oCalcReset  (calc_reset),
      .oCalcValid  (calc_valid),
      .oCalcACF1   (calc_acf1),
      .oCalcACF2   (calc_acf2),
      .oCalcModel1 (calc_model1),
      .oCalcModel2 (calc_model2),
      .oCalcM      (calc_m),
      .iCalcAlpha  (calc_alpha),
      .iCalcDone   (calc_done),
      .oAlpha      (alpha),
      .oDone       (done),
      .oBusy       (busy),
      .oError      (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [3:0] mv);
      start = 1'b1;
      m_in  = mv;
      step();
      start = 1'b0;
   endtask

   task automatic check_beat(input string tag, input logic [31:0] m1, input logic [31:0] a2,
                             input logic [31:0] m2, input logic [31:0] a1);
      check({tag, ".valid"},  32'(calc_valid), 32'd1);
      check({tag, ".model1"}, calc_model1, m1);
      check({tag, ".acf2"},   calc_acf2,   a2);
      check({tag, ".model2"}, calc_model2, m2);
      check({tag, ".acf1"},   calc_acf1,   a1);
   endtask

   // Order-12 pair k: model[2k]*acf[13-2k] and model[2k+1]*acf[12-2k]; k=6 pads
   task automatic check_m12_beat(input string tag, input int k);
      logic [31:0] m2, a1;
      m2 = (k == 6) ? 32'h0 : model_mem[2*k+1];
      a1 = (k == 6) ? 32'h0 : acf_mem[12-2*k];
      check_beat(tag, model_mem[2*k], acf_mem[13-2*k], m2, a1);
   endtask

   task automatic finish_op(input string tag, input logic [31:0] a);
      calc_alpha = a;
      calc_done  = 1'b1;
      step();
      check({tag, ".done"},  32'(done), 32'd1);
      check({tag, ".alpha"}, alpha, a);
      check({tag, ".idle"},  32'(busy), 32'd0);
      calc_done = 1'b0;
      step();
      check({tag, ".done_pulse"}, 32'(done), 32'd0);
      $display("[TB] %s complete: alpha=%h", tag, alpha);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int early;
      int valid_count;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 32'hB000_0000 | 32'(i);
         acf_mem[i]   = 32'hA000_0000 | 32'(i);
      end
      model_mem[0] = 32'h3F80_0000;   // 1.0
      model_mem[1] = 32'h3F00_0000;   // 0.5
      acf_mem[0]   = 32'h4080_0000;   // 4.0
      acf_mem[1]   = 32'h4000_0000;   // 2.0
      acf_mem[2]   = 32'h3F80_0000;   // 1.0

      rst = 1'b1; en = 1'b1; start = 1'b0; m_in = '0;
      calc_done = 1'b0; calc_alpha = '0;
      step(); step();
      check("rst.busy",   32'(busy),       32'd0);
      check("rst.valid",  32'(calc_valid), 32'd0);
      check("rst.creset", 32'(calc_reset), 32'd0);
      check("rst.done",   32'(done),       32'd0);
      check("rst.error",  32'(err),        32'd0);
      check("rst.alpha",  alpha,           32'd0);
      check("rst.acf1",   calc_acf1,       32'd0);
      check("rst.maddr2", 32'(model_addr2), 32'd0);
      rst = 1'b0;
      step();

      // Order 1: single beat, no padding
      start_op(4'd1);
      check("m1.creset",  32'(calc_reset), 32'd1);
      check("m1.busy",    32'(busy),       32'd1);
      check("m1.calc_m",  32'(calc_m),     32'd1);
      step();
      check("m1.creset_pulse", 32'(calc_reset), 32'd0);
      check("m1.no_valid",     32'(calc_valid), 32'd0);
      check("m1.acf_addr1",    32'(acf_addr1),  32'd1);
      check("m1.acf_addr2",    32'(acf_addr2),  32'd2);
      check("m1.model_addr1",  32'(model_addr1), 32'd0);
      check("m1.model_addr2",  32'(model_addr2), 32'd1);
      step();
      check_beat("m1.beat0", 32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h4000_0000);
      step();
      check("m1.valid_end", 32'(calc_valid), 32'd0);
      check("m1.addr_hold", 32'(acf_addr2),  32'd2);
      finish_op("m1", 32'h4000_0000);

      // Order 2: two beats, second padded
      start_op(4'd2);
      step(); step();
      check_beat("m2.beat0", 32'h3F80_0000, 32'hA000_0003, 32'h3F00_0000, 32'h3F80_0000);
      step();
      check_beat("m2.beat1", 32'hB000_0002, 32'h4000_0000, 32'h0, 32'h0);
      step();
      check("m2.valid_end", 32'(calc_valid), 32'd0);
      finish_op("m2", 32'h3F00_0000);

      // Order 12: seven consecutive beats, first valid 3 cycles after start
      start_op(4'd12);
      check("m12.calc_m", 32'(calc_m), 32'd12);
      step();
      check("m12.valid_c2", 32'(calc_valid), 32'd0);
      step();
      for (int k = 0; k < 7; k++) begin
         check_m12_beat($sformatf("m12.beat%0d", k), k);
         step();
      end
      check("m12.valid_end", 32'(calc_valid), 32'd0);
      finish_op("m12", 32'hC000_0000);

      // Illegal orders 0 and 13
      start_op(4'd0);
      check("bad0.error",  32'(err),        32'd1);
      check("bad0.busy",   32'(busy),       32'd0);
      check("bad0.creset", 32'(calc_reset), 32'd0);
      step();
      check("bad0.error_pulse", 32'(err), 32'd0);
      start_op(4'd13);
      check("bad13.error",  32'(err),        32'd1);
      check("bad13.busy",   32'(busy),       32'd0);
      check("bad13.creset", 32'(calc_reset), 32'd0);
      check("bad13.calc_m", 32'(calc_m),     32'd12);
      step();
      check("bad13.error_pulse", 32'(err), 32'd0);
      $display("[TB] illegal orders 0 and 13 rejected");

      // Timeout: WAIT entered 3 cycles after CLEAR, error TIMEOUT cycles later
      start_op(4'd1);
      early = 0;
      for (int i = 0; i < 66; i++) begin
         step();
         if (err || done) early++;
      end
      check("tmo.early", 32'(early), 32'd0);
      check("tmo.busy_before", 32'(busy), 32'd1);
      step();
      check("tmo.error", 32'(err),  32'd1);
      check("tmo.alpha", alpha,     32'hC000_0000);
      check("tmo.idle",  32'(busy), 32'd0);
      check("tmo.done",  32'(done), 32'd0);
      step();
      check("tmo.error_pulse", 32'(err), 32'd0);
      $display("[TB] timeout op complete: alpha=%h", alpha);

      // Enable freeze mid-ISSUE, ignored start while busy, reset mid-WAIT
      start_op(4'd12);
      step(); step();
      check_m12_beat("frz.beat0", 0);
      step();
      check_m12_beat("frz.beat1", 1);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_m12_beat($sformatf("frz.hold%0d", i), 1);
      end
      en = 1'b1;
      start = 1'b1;
      m_in  = 4'd3;
      valid_count = 2;
      for (int k = 2; k < 7; k++) begin
         step();
         start = 1'b0;
         check_m12_beat($sformatf("frz.beat%0d", k), k);
         valid_count++;
      end
      step();
      check("frz.valid_end", 32'(calc_valid), 32'd0);
      check("frz.calc_m",    32'(calc_m),     32'd12);
      check("frz.beats",     32'(valid_count), 32'd7);
      step(); step();
      check("frz.busy_wait", 32'(busy), 32'd1);
      rst        = 1'b1;
      calc_done  = 1'b1;
      calc_alpha = 32'h1234_5678;
      step();
      check("frz.rst_done",   32'(done),        32'd0);
      check("frz.rst_busy",   32'(busy),        32'd0);
      check("frz.rst_alpha",  alpha,            32'd0);
      check("frz.rst_calc_m", 32'(calc_m),      32'd0);
      check("frz.rst_maddr1", 32'(model_addr1), 32'd0);
      check("frz.rst_maddr2", 32'(model_addr2), 32'd0);
      check("frz.rst_aaddr2", 32'(acf_addr2),   32'd0);
      rst       = 1'b0;
      calc_done = 1'b0;
      step();
      check("frz.post_done", 32'(done), 32'd0);
      check("frz.post_busy", 32'(busy), 32'd0);
      $display("[TB] freeze/reset op complete: alpha=%h", alpha);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
